mul_stream_engine: RTL and testbench

//  Parametrised successor of the kadai-series operand/product engine.
//  - Requests operand pairs A/B with a REQ_AB/ACK handshake and buffers them in an input FIFO.
//  - Multiplies each pair, or multiply-accumulates a run of pairs.
//  - Queues results in an output FIFO drained by an X_VALID/X_READY handshake.
//  - Sits between an operand source and a result consumer; START/HALT gate operand intake.

---
 rtl/mul_stream_engine.sv | 279 +++++++++++++++++++++++++++
 tb/tb_mul_stream_engine.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_stream_engine.sv
// Streaming multiply / multiply-accumulate engine: handshaked operand intake into an
// input FIFO, a one-stage product pipeline, and a first-word-fall-through result FIFO.

module mul_stream_engine_chk #(
  parameter int CW    = 3,
  parameter int DEPTH = 4,
  parameter int XW    = 20
) (
  input logic          clk,
  input logic          rst,
  input logic [CW-1:0] in_count,
  input logic [CW-1:0] out_count,
  input logic          in_push,
  input logic          in_pop,
  input logic          out_push,
  input logic          out_pop,
  input logic          x_valid,
  input logic          x_ready,
  input logic [XW-1:0] x
);

  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  a_in_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(in_push && !in_pop && (in_count == DEPTH_CNT)));

  a_in_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(in_pop && (in_count == {CW{1'b0}})));

  a_out_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(out_push && !out_pop && (out_count == DEPTH_CNT)));

  a_x_stable: assert property (@(posedge clk) disable iff (rst)
    (x_valid && !x_ready) |=> (x_valid && $stable(x)));

endmodule

module mul_stream_engine #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  parameter  int ACCW  = 4,
  localparam int XW    = 2*WIDTH + ACCW
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             HALT,
  input  logic             MODE,
  input  logic [7:0]       ACC_LEN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ACK,
  output logic             REQ_AB,
  output logic [XW-1:0]    X,
  output logic             X_VALID,
  input  logic             X_READY,
  output logic             BUSY
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int PW = 2*WIDTH;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t           state_r;
  logic             mode_r;
  logic [7:0]       acc_len_r;

  logic [WIDTH-1:0] in_a_mem_r [DEPTH];
  logic [WIDTH-1:0] in_b_mem_r [DEPTH];
  logic [AW-1:0]    in_wr_ptr_r;
  logic [AW-1:0]    in_rd_ptr_r;
  logic [CW-1:0]    in_count_r;

  logic [PW-1:0]    p_r;
  logic             p_valid_r;
  logic [XW-1:0]    acc_r;
  logic [7:0]       acc_cnt_r;

  logic [XW-1:0]    out_mem_r [DEPTH];
  logic [AW-1:0]    out_wr_ptr_r;
  logic [AW-1:0]    out_rd_ptr_r;
  logic [CW-1:0]    out_count_r;
  logic [XW-1:0]    x_r;
  logic             x_valid_r;

  logic             start_ok_s;
  logic             run_entry_s;
  logic             req_ab_s;
  logic             in_push_s;
  logic             in_pop_s;
  logic [PW-1:0]    p_next_s;
  logic [7:0]       acc_len_eff_s;
  logic             acc_last_s;
  logic [XW-1:0]    acc_sum_s;
  logic             out_push_s;
  logic             out_pop_s;
  logic [XW-1:0]    out_data_s;
  logic [CW-1:0]    out_count_next_s;
  logic [CW-1:0]    out_rem_s;
  logic [AW-1:0]    out_rd_ptr_next_s;
  logic [XW-1:0]    head_next_s;
  logic             data_pending_s;

  // Handshake, issue credit and accumulate decode.
  always_comb begin
    start_ok_s     = START && !HALT;
    run_entry_s    = (state_r == ST_IDLE) && start_ok_s;
    req_ab_s       = (state_r == ST_RUN) && (in_count_r < DEPTH_CNT);
    in_push_s      = ACK && req_ab_s;
    // Credit counts the product in flight so the output FIFO can never overflow.
    in_pop_s       = (in_count_r != {CW{1'b0}}) &&
                     ((out_count_r + CW'(p_valid_r)) < DEPTH_CNT);
    p_next_s       = {{WIDTH{1'b0}}, in_a_mem_r[in_rd_ptr_r]} *
                     {{WIDTH{1'b0}}, in_b_mem_r[in_rd_ptr_r]};
    acc_len_eff_s  = (acc_len_r == 8'd0) ? 8'd1 : acc_len_r;
    acc_last_s     = (({1'b0, acc_cnt_r} + 9'd1) == {1'b0, acc_len_eff_s});
    acc_sum_s      = acc_r + {{ACCW{1'b0}}, p_r};
    out_push_s     = p_valid_r && (!mode_r || acc_last_s);
    out_data_s     = mode_r ? acc_sum_s : {{ACCW{1'b0}}, p_r};
    out_pop_s      = x_valid_r && X_READY;
    data_pending_s = (in_count_r != {CW{1'b0}}) || p_valid_r ||
                     (out_count_r != {CW{1'b0}}) || (acc_cnt_r != 8'd0);
  end

  // Next head of the result FIFO, so X and X_VALID can be driven from registers.
  always_comb begin
    out_count_next_s  = out_count_r + CW'(out_push_s) - CW'(out_pop_s);
    out_rem_s         = out_count_r - CW'(out_pop_s);
    out_rd_ptr_next_s = out_rd_ptr_r + AW'(out_pop_s);
    if (out_count_next_s == {CW{1'b0}}) begin
      head_next_s = {XW{1'b0}};
    end else if (out_rem_s == {CW{1'b0}}) begin
      head_next_s = out_data_s;
    end else begin
      head_next_s = out_mem_r[out_rd_ptr_next_s];
    end
  end

  // Run-control FSM; MODE and ACC_LEN are only captured when leaving IDLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      mode_r    <= 1'b0;
      acc_len_r <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_ok_s) begin
            state_r   <= ST_RUN;
            mode_r    <= MODE;
            acc_len_r <= ACC_LEN;
          end
        end
        ST_RUN: begin
          if (HALT) begin
            state_r <= ST_HALTED;
          end
        end
        ST_HALTED: begin
          if (start_ok_s) begin
            state_r <= ST_RUN;
          end else if (!data_pending_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Input FIFO storage; stale entries are harmless because the pointers reset.
  always_ff @(posedge CLK) begin
    if (!RST && in_push_s) begin
      in_a_mem_r[in_wr_ptr_r] <= A;
      in_b_mem_r[in_wr_ptr_r] <= B;
    end
  end

  // Input FIFO pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (RST) begin
      in_wr_ptr_r <= {AW{1'b0}};
      in_rd_ptr_r <= {AW{1'b0}};
      in_count_r  <= {CW{1'b0}};
    end else begin
      if (in_push_s) begin
        in_wr_ptr_r <= in_wr_ptr_r + AW'(1'b1);
      end
      if (in_pop_s) begin
        in_rd_ptr_r <= in_rd_ptr_r + AW'(1'b1);
      end
      in_count_r <= in_count_r + CW'(in_push_s) - CW'(in_pop_s);
    end
  end

  // Product register and accumulator; a new run always starts from a clean sum.
  always_ff @(posedge CLK) begin
    if (RST) begin
      p_r       <= {PW{1'b0}};
      p_valid_r <= 1'b0;
      acc_r     <= {XW{1'b0}};
      acc_cnt_r <= 8'd0;
    end else begin
      p_valid_r <= in_pop_s;
      if (in_pop_s) begin
        p_r <= p_next_s;
      end
      if (run_entry_s) begin
        acc_r     <= {XW{1'b0}};
        acc_cnt_r <= 8'd0;
      end else if (p_valid_r && mode_r) begin
        if (acc_last_s) begin
          acc_r     <= {XW{1'b0}};
          acc_cnt_r <= 8'd0;
        end else begin
          acc_r     <= acc_sum_s;
          acc_cnt_r <= acc_cnt_r + 8'd1;
        end
      end
    end
  end

  // Result FIFO storage.
  always_ff @(posedge CLK) begin
    if (!RST && out_push_s) begin
      out_mem_r[out_wr_ptr_r] <= out_data_s;
    end
  end

  // Result FIFO pointers, occupancy and registered head.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_wr_ptr_r <= {AW{1'b0}};
      out_rd_ptr_r <= {AW{1'b0}};
      out_count_r  <= {CW{1'b0}};
      x_r          <= {XW{1'b0}};
      x_valid_r    <= 1'b0;
    end else begin
      if (out_push_s) begin
        out_wr_ptr_r <= out_wr_ptr_r + AW'(1'b1);
      end
      out_rd_ptr_r <= out_rd_ptr_next_s;
      out_count_r  <= out_count_next_s;
      x_r          <= head_next_s;
      x_valid_r    <= (out_count_next_s != {CW{1'b0}});
    end
  end

  assign REQ_AB  = req_ab_s;
  assign X       = x_r;
  assign X_VALID = x_valid_r;
  assign BUSY    = (state_r == ST_RUN) || data_pending_s;

  mul_stream_engine_chk #(
    .CW    (CW),
    .DEPTH (DEPTH),
    .XW    (XW)
  ) u_chk (
    .clk       (CLK),
    .rst       (RST),
    .in_count  (in_count_r),
    .out_count (out_count_r),
    .in_push   (in_push_s),
    .in_pop    (in_pop_s),
    .out_push  (out_push_s),
    .out_pop   (out_pop_s),
    .x_valid   (x_valid_r),
    .x_ready   (X_READY),
    .x         (x_r)
  );

endmodule

// File: tb/tb_mul_stream_engine.sv
// Self-checking bench for mul_stream_engine: vector table plus scoreboard of expected
// results, with hand-written sequences for latency, backpressure, halt and reset.

module tb_mul_stream_engine;

  localparam int XW = 20;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic          HALT = 1'b0;
  logic          MODE = 1'b0;
  logic [7:0]    ACC_LEN = 8'd0;
  logic [7:0]    A = 8'd0;
  logic [7:0]    B = 8'd0;
  logic          ACK = 1'b0;
  logic          X_READY = 1'b1;
  logic          REQ_AB;
  logic [XW-1:0] X;
  logic          X_VALID;
  logic          BUSY;

  int            n_tests = 0;
  int            n_fail = 0;
  int            n_out = 0;
  bit            rand_ready = 1'b0;
  logic [XW-1:0] exp_q[$];

  typedef struct {
    logic [7:0]    a;
    logic [7:0]    b;
    logic [XW-1:0] x;
  } vec_t;

  vec_t tbl[8];

  mul_stream_engine #(.WIDTH(8), .DEPTH(4), .ACCW(4)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .HALT    (HALT),
    .MODE    (MODE),
    .ACC_LEN (ACC_LEN),
    .A       (A),
    .B       (B),
    .ACK     (ACK),
    .REQ_AB  (REQ_AB),
    .X       (X),
    .X_VALID (X_VALID),
    .X_READY (X_READY),
    .BUSY    (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: a transfer happens on the next rising edge when both are high here.
  always @(negedge CLK) begin
    if (!RST && X_VALID && X_READY) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_x: got 0x%0h, expected no result", X);
      end else begin
        check("x_value", 32'(X), 32'(exp_q.pop_front()));
      end
    end
  end

  always @(posedge CLK) begin
    if (rand_ready) begin
      #2;
      X_READY = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input bit has_out, input logic [XW-1:0] exp);
    int  waited = 0;
    bit  done = 1'b0;
    A   = a;
    B   = b;
    ACK = 1'b1;
    while (!done) begin
      @(negedge CLK);
      if (REQ_AB && !RST) begin
        if (has_out) exp_q.push_back(exp);
        done = 1'b1;
      end
      @(posedge CLK);
      #1;
      if (!done) begin
        waited++;
        if (waited > 60) begin
          n_tests++;
          n_fail++;
          $display("FAIL send_timeout: REQ_AB stayed 0 for pair 0x%0h,0x%0h", a, b);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic start_run(input logic m, input logic [7:0] len);
    MODE    = m;
    ACC_LEN = len;
    START   = 1'b1;
    @(posedge CLK);
    #1;
    START   = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(posedge CLK);
      #1;
      waited++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic stop_to_idle();
    int waited = 0;
    ACK  = 1'b0;
    HALT = 1'b1;
    @(posedge CLK);
    #1;
    while (BUSY && waited < 200) begin
      @(posedge CLK);
      #1;
      waited++;
    end
    check("halt_busy", 32'(BUSY), 32'd0);
    @(posedge CLK);
    #1;
    HALT = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XW-1:0] e;
    logic [XW-1:0] x_hold;
    logic [7:0]    ta;
    logic [7:0]    tb;
    int            out0;
    int            waited;

    tbl[0] = '{8'h4a, 8'h5b, 20'h01A4E};
    tbl[1] = '{8'hFF, 8'hFF, 20'h0FE01};
    tbl[2] = '{8'h00, 8'h37, 20'h00000};
    tbl[3] = '{8'h01, 8'h01, 20'h00001};
    tbl[4] = '{8'h80, 8'h02, 20'h00100};
    tbl[5] = '{8'h12, 8'h34, 20'h003A8};
    tbl[6] = '{8'h0F, 8'hF0, 20'h00E10};
    tbl[7] = '{8'hAA, 8'h55, 20'h03872};

    // Reset: two cycles, all outputs low.
    repeat (2) @(posedge CLK);
    #1;
    check("rst_req_ab", 32'(REQ_AB), 32'd0);
    check("rst_x_valid", 32'(X_VALID), 32'd0);
    check("rst_x", 32'(X), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    RST = 1'b0;

    // Single-pair latency and one-cycle-wide X_VALID.
    start_run(1'b0, 8'd0);
    check("run_req_ab", 32'(REQ_AB), 32'd1);
    send(8'h4a, 8'h5b, 1'b1, 20'h01A4E);
    ACK = 1'b0;
    @(posedge CLK); #1;
    check("lat_n1_valid", 32'(X_VALID), 32'd0);
    @(posedge CLK); #1;
    check("lat_n2_valid", 32'(X_VALID), 32'd1);
    check("lat_n2_x", 32'(X), 32'h01A4E);
    @(posedge CLK); #1;
    check("lat_n3_valid", 32'(X_VALID), 32'd0);

    // Back-to-back pairs give results on consecutive cycles.
    send(8'hFF, 8'hFF, 1'b1, 20'h0FE01);
    send(8'h00, 8'h37, 1'b1, 20'h00000);
    send(8'h01, 8'h01, 1'b1, 20'h00001);
    ACK = 1'b0;
    check("b2b_x0", {31'd0, X_VALID} << 20 | 32'(X), 32'h0010FE01);
    @(posedge CLK); #1;
    check("b2b_x1", {31'd0, X_VALID} << 20 | 32'(X), 32'h00100000);
    @(posedge CLK); #1;
    check("b2b_x2", {31'd0, X_VALID} << 20 | 32'(X), 32'h00100001);
    drain();

    // Vector table, first with the consumer always ready, then with random backpressure.
    for (int pass = 0; pass < 2; pass++) begin
      rand_ready = (pass == 1);
      for (int i = 0; i < 8; i++) begin
        send(tbl[i].a, tbl[i].b, 1'b1, tbl[i].x);
      end
      ACK = 1'b0;
      rand_ready = 1'b0;
      @(posedge CLK); #1;
      X_READY = 1'b1;
      drain();
    end

    // Multiply-accumulate: ACC_LEN=3, then a 17-term wrap, then ACC_LEN=0 acting as 1.
    stop_to_idle();
    start_run(1'b1, 8'd3);
    send(8'd1, 8'd2, 1'b0, 20'd0);
    send(8'd3, 8'd4, 1'b0, 20'd0);
    send(8'd5, 8'd6, 1'b1, 20'h0002C);
    ACK = 1'b0;
    drain();
    stop_to_idle();
    start_run(1'b1, 8'd17);
    for (int i = 0; i < 17; i++) begin
      send(8'hFF, 8'hFF, (i == 16), 20'h0DE11);
    end
    ACK = 1'b0;
    drain();
    stop_to_idle();
    start_run(1'b1, 8'd0);
    send(8'd3, 8'd5, 1'b1, 20'd15);
    send(8'd7, 8'd7, 1'b1, 20'd49);
    ACK = 1'b0;
    drain();

    // Halt mid-accumulation: resume keeps the latched mode and the partial sum.
    stop_to_idle();
    start_run(1'b1, 8'd4);
    send(8'd2, 8'd3, 1'b0, 20'd0);
    send(8'd4, 8'd5, 1'b0, 20'd0);
    ACK  = 1'b0;
    HALT = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
    check("halt_acc_busy", 32'(BUSY), 32'd1);
    check("halt_acc_req", 32'(REQ_AB), 32'd0);
    MODE    = 1'b0;
    ACC_LEN = 8'd1;
    HALT    = 1'b0;
    START   = 1'b1;
    @(posedge CLK); #1;
    START   = 1'b0;
    check("resume_req", 32'(REQ_AB), 32'd1);
    send(8'd1, 8'd1, 1'b0, 20'd0);
    send(8'd2, 8'd2, 1'b1, 20'h0001F);
    ACK = 1'b0;
    drain();
    stop_to_idle();

    // Backpressure: 2*DEPTH pairs fill both FIFOs, then nothing more is accepted.
    start_run(1'b0, 8'd0);
    X_READY = 1'b0;
    x_hold  = 20'd0;
    for (int i = 0; i < 12; i++) begin
      ta = 8'(i * 17 + 3);
      tb = 8'(i * 5 + 9);
      e  = XW'(ta) * XW'(tb);
      if (i == 0) x_hold = e;
      if (i == 8) begin
        ACK = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("full_req_ab", 32'(REQ_AB), 32'd0);
        check("full_x_valid", 32'(X_VALID), 32'd1);
        check("full_x_head", 32'(X), 32'(x_hold));
        A   = ta;
        B   = tb;
        ACK = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("full_req_ab_held", 32'(REQ_AB), 32'd0);
        check("full_x_stable", 32'(X), 32'(x_hold));
        X_READY = 1'b1;
      end
      send(ta, tb, 1'b1, e);
    end
    ACK = 1'b0;
    drain();

    // HALT after three of six pairs: intake stops, buffered results drain, START resumes.
    out0 = n_out;
    for (int i = 0; i < 6; i++) begin
      ta = 8'(i + 2);
      tb = 8'(i + 7);
      e  = XW'(ta) * XW'(tb);
      if (i == 3) begin
        ACK  = 1'b0;
        HALT = 1'b1;
        @(posedge CLK); #1;
        check("halt_req_ab", 32'(REQ_AB), 32'd0);
        A = ta;
        B = tb;
        ACK = 1'b1;
        waited = 0;
        while (BUSY && waited < 100) begin
          @(posedge CLK); #1;
          waited++;
        end
        check("halt_busy_fall", 32'(BUSY), 32'd0);
        check("halt_results", 32'(n_out - out0), 32'd3);
        check("halt_req_ab_idle", 32'(REQ_AB), 32'd0);
        HALT = 1'b0;
        start_run(1'b0, 8'd0);
      end
      send(ta, tb, 1'b1, e);
    end
    ACK = 1'b0;
    drain();
    check("halt_total", 32'(n_out - out0), 32'd6);

    // Reset with both FIFOs occupied discards everything, including the pair ACKed then.
    X_READY = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ta = 8'(i + 30);
      tb = 8'(i + 40);
      send(ta, tb, 1'b1, XW'(ta) * XW'(tb));
    end
    ACK = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("pre_rst_valid", 32'(X_VALID), 32'd1);
    RST = 1'b1;
    A   = 8'h77;
    B   = 8'h66;
    ACK = 1'b1;
    @(posedge CLK); #1;
    check("mid_rst_req_ab", 32'(REQ_AB), 32'd0);
    check("mid_rst_x_valid", 32'(X_VALID), 32'd0);
    check("mid_rst_x", 32'(X), 32'd0);
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    exp_q.delete();
    RST     = 1'b0;
    ACK     = 1'b0;
    X_READY = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    start_run(1'b0, 8'd0);
    repeat (5) @(posedge CLK);
    #1;
    check("post_rst_no_stale", 32'(X_VALID), 32'd0);
    check("post_rst_busy_run", 32'(BUSY), 32'd1);
    send(8'd9, 8'd9, 1'b1, 20'd81);
    ACK = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
